// File: rtl/dx_tile_sched_pkg.sv
// Shared state encoding and default sizing for the dx tile scheduler.
package dx_tile_sched_pkg;

    localparam int DEF_CNT_W     = 8;
    localparam int DEF_RD_LAT    = 1;
    localparam int DEF_OUT_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/dx_credit_cnt.sv
// Saturating up/down credit counter; starts full, flags pops at full and issues at empty.
module dx_credit_cnt
    import dx_tile_sched_pkg::*;
#(
    parameter int DEPTH = DEF_OUT_DEPTH
) (
    input  logic clk,
    input  logic rstn,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_o,
    output logic ovf_o,
    output logic unf_o
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          full;
    logic          inc_ok, dec_ok;

    assign full   = (cnt_q == CW'(DEPTH));
    assign zero_o = (cnt_q == '0);
    assign ovf_o  = inc_i && full;
    assign unf_o  = dec_i && zero_o;

    // NOTE: every variable gets its default first, so no branch can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d  = cnt_q;
        inc_ok = inc_i && !full;
        dec_ok = dec_i && !zero_o;
        if (inc_ok && !dec_ok) begin
            cnt_d = cnt_q + CW'(1);
        end else if (dec_ok && !inc_ok) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // NOTE: state updates use non-blocking assignment so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= CW'(DEPTH);
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dx_tile_sched.sv
// Tile scheduler for the dx pass: walks h (outer) by p (inner), issues operand reads
// under FIFO credit, and counts multiplier returns before signalling completion.
module dx_tile_sched
    import dx_tile_sched_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MUL_LAT   = 6,
    parameter int RD_LAT    = DEF_RD_LAT,
    parameter int OUT_DEPTH = DEF_OUT_DEPTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start_i,
    input  logic [CNT_W-1:0]     num_h_i,
    input  logic [CNT_W-1:0]     num_p_i,
    output logic                 rd_en_o,
    output logic [CNT_W-1:0]     h_addr_o,
    output logic [2*CNT_W-1:0]   x_addr_o,
    output logic                 mul_valid_o,
    output logic                 mul_last_o,
    input  logic                 mul_valid_i,
    input  logic                 out_pop_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int XW = 2 * CNT_W;
    localparam int RW = XW + 1;

    if (RD_LAT < 1 || MUL_LAT < 1) begin : g_bad_param
        $error("dx_tile_sched: RD_LAT and MUL_LAT must both be at least 1");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   num_h_q, num_h_d;
    logic [CNT_W-1:0]   num_p_q, num_p_d;
    logic [CNT_W-1:0]   h_idx_q, h_idx_d;
    logic [CNT_W-1:0]   p_idx_q, p_idx_d;
    logic [XW-1:0]      total_q, total_d;
    logic [XW-1:0]      x_addr_q, x_addr_d;
    logic [RW-1:0]      ret_cnt_q, ret_cnt_d;
    logic               err_q, err_d;
    logic [RD_LAT-1:0]  vld_sr_q, vld_sr_d;
    logic [RD_LAT-1:0]  last_sr_q, last_sr_d;

    logic issue, last_issue, ret_done;
    logic cred_zero, cred_ovf, cred_unf;

    assign ret_done = (ret_cnt_q == RW'(total_q));

    dx_credit_cnt #(
        .DEPTH (OUT_DEPTH)
    ) u_credit (
        .clk    (clk),
        .rstn   (rstn),
        .inc_i  (out_pop_i),
        .dec_i  (issue),
        .zero_o (cred_zero),
        .ovf_o  (cred_ovf),
        .unf_o  (cred_unf)
    );

    always_comb begin
        state_d    = state_q;
        num_h_d    = num_h_q;
        num_p_d    = num_p_q;
        h_idx_d    = h_idx_q;
        p_idx_d    = p_idx_q;
        total_d    = total_q;
        x_addr_d   = x_addr_q;
        ret_cnt_d  = ret_cnt_q;
        err_d      = err_q;
        issue      = 1'b0;
        last_issue = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    num_h_d   = num_h_i;
                    num_p_d   = num_p_i;
                    total_d   = XW'(num_h_i) * XW'(num_p_i);
                    h_idx_d   = '0;
                    p_idx_d   = '0;
                    x_addr_d  = '0;
                    ret_cnt_d = '0;
                    err_d     = 1'b0;
                    state_d   = (num_h_i == '0 || num_p_i == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                issue = !cred_zero;
                if (issue) begin
                    // With h outer and p inner the linear x address is just the issue count.
                    x_addr_d = x_addr_q + XW'(1);
                    if (p_idx_q == num_p_q - CNT_W'(1)) begin
                        p_idx_d = '0;
                        if (h_idx_q == num_h_q - CNT_W'(1)) begin
                            last_issue = 1'b1;
                            state_d    = ST_DRAIN;
                        end else begin
                            h_idx_d = h_idx_q + CNT_W'(1);
                        end
                    end else begin
                        p_idx_d = p_idx_q + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q == ST_RUN || state_q == ST_DRAIN) && mul_valid_i && !ret_done) begin
            ret_cnt_d = ret_cnt_q + RW'(1);
            if (state_q == ST_DRAIN && ret_cnt_d == RW'(total_q)) begin
                state_d = ST_DONE;
            end
        end

        if (cred_ovf || cred_unf || (mul_valid_i && (state_q == ST_IDLE || ret_done))) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        vld_sr_d     = vld_sr_q;
        last_sr_d    = last_sr_q;
        vld_sr_d[0]  = issue;
        last_sr_d[0] = last_issue;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_sr_d[i]  = vld_sr_q[i-1];
            last_sr_d[i] = last_sr_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            num_h_q   <= '0;
            num_p_q   <= '0;
            h_idx_q   <= '0;
            p_idx_q   <= '0;
            total_q   <= '0;
            x_addr_q  <= '0;
            ret_cnt_q <= '0;
            err_q     <= 1'b0;
            // NOTE: the read delay line is reset too; a stale strobe would fake a multiplier issue after abort.
            vld_sr_q  <= '0;
            last_sr_q <= '0;
        end else begin
            state_q   <= state_d;
            num_h_q   <= num_h_d;
            num_p_q   <= num_p_d;
            h_idx_q   <= h_idx_d;
            p_idx_q   <= p_idx_d;
            total_q   <= total_d;
            x_addr_q  <= x_addr_d;
            ret_cnt_q <= ret_cnt_d;
            err_q     <= err_d;
            vld_sr_q  <= vld_sr_d;
            last_sr_q <= last_sr_d;
        end
    end

    assign rd_en_o     = issue;
    assign h_addr_o    = h_idx_q;
    assign x_addr_o    = x_addr_q;
    assign mul_valid_o = vld_sr_q[RD_LAT-1];
    assign mul_last_o  = last_sr_q[RD_LAT-1];
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign err_o       = err_q;

endmodule

// File: tb/tb_dx_tile_sched.sv
// Scoreboard bench for dx_tile_sched: stimulus queues expected issues, multiplier
// strobes and done pulses with cycle stamps; a negedge monitor pops and compares.
module tb_dx_tile_sched;

    localparam int CNT_W     = 8;
    localparam int MUL_LAT   = 6;
    localparam int RD_LAT    = 1;
    localparam int OUT_DEPTH = 4;

    logic               clk;
    logic               rstn;
    logic               start_i;
    logic [CNT_W-1:0]   num_h_i;
    logic [CNT_W-1:0]   num_p_i;
    logic               rd_en_o;
    logic [CNT_W-1:0]   h_addr_o;
    logic [2*CNT_W-1:0] x_addr_o;
    logic               mul_valid_o;
    logic               mul_last_o;
    logic               mul_valid_i;
    logic               out_pop_i;
    logic               busy_o;
    logic               done_o;
    logic               err_o;

    dx_tile_sched #(
        .CNT_W     (CNT_W),
        .MUL_LAT   (MUL_LAT),
        .RD_LAT    (RD_LAT),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start_i     (start_i),
        .num_h_i     (num_h_i),
        .num_p_i     (num_p_i),
        .rd_en_o     (rd_en_o),
        .h_addr_o    (h_addr_o),
        .x_addr_o    (x_addr_o),
        .mul_valid_o (mul_valid_o),
        .mul_last_o  (mul_last_o),
        .mul_valid_i (mul_valid_i),
        .out_pop_i   (out_pop_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stand-in: fixed-latency valid pipe, cleared with the block.
    logic [MUL_LAT-1:0] mpipe;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) mpipe <= '0;
        else       mpipe <= {mpipe[MUL_LAT-2:0], mul_valid_o};
    end
    assign mul_valid_i = mpipe[MUL_LAT-1];

    typedef struct {
        int cyc;
        int h;
        int x;
        bit last;
    } exp_t;

    exp_t iss_q[$];
    exp_t mul_q[$];
    int   done_q[$];
    int   done_cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_iss(input int c, input int h, input int x);
        exp_t e;
        e.cyc = c; e.h = h; e.x = x; e.last = 1'b0;
        iss_q.push_back(e);
    endfunction

    function automatic void push_mul(input int c, input bit last);
        exp_t e;
        e.cyc = c; e.h = 0; e.x = 0; e.last = last;
        mul_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   dc;
        if (rd_en_o) begin
            check("issue_expected", iss_q.size() > 0, 1);
            if (iss_q.size() > 0) begin
                e = iss_q.pop_front();
                check("issue_cycle", cyc, e.cyc);
                check("h_addr", h_addr_o, e.h);
                check("x_addr", x_addr_o, e.x);
            end
        end
        if (mul_valid_o) begin
            check("mul_expected", mul_q.size() > 0, 1);
            if (mul_q.size() > 0) begin
                e = mul_q.pop_front();
                check("mul_cycle", cyc, e.cyc);
                check("mul_last", mul_last_o, e.last);
            end
        end
        if (done_o) begin
            done_cnt++;
            check("done_expected", done_q.size() > 0, 1);
            if (done_q.size() > 0) begin
                dc = done_q.pop_front();
                check("done_cycle", cyc, dc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int bound);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < bound) begin
            tick();
            n++;
        end
        check("done_seen", done_cnt != d0, 1);
    endtask

    task automatic queues_empty(input string tag);
        check({tag, "_issues_left"}, iss_q.size(), 0);
        check({tag, "_muls_left"}, mul_q.size(), 0);
        check({tag, "_dones_left"}, done_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, rd_en_o, 0);
        check({tag, "_mul_valid"}, mul_valid_o, 0);
        check({tag, "_mul_last"}, mul_last_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_h_addr"}, h_addr_o, 0);
        check({tag, "_x_addr"}, x_addr_o, 0);
    endtask

    // 2x3 job with a pop every cycle: issues back to back, returns MUL_LAT+RD_LAT later.
    task automatic run_2x3(input string tag);
        int s;
        s = cyc;
        num_h_i = 8'd2; num_p_i = 8'd3; start_i = 1'b1; out_pop_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_iss(s + 1 + i, i / 3, i);
            push_mul(s + 2 + i, i == 5);
        end
        done_q.push_back(s + 14);
        tick();
        start_i = 1'b0;
        wait_done(40);
        out_pop_i = 1'b0;
        tick();
        tick();
        queues_empty(tag);
        check({tag, "_idle_busy"}, busy_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s;
        rstn = 1'b1; start_i = 1'b0; num_h_i = '0; num_p_i = '0; out_pop_i = 1'b0;
        #1 rstn = 1'b0;
        #2 check_all_zero("reset");
        tick();
        tick();
        rstn = 1'b1;
        tick();

        run_2x3("basic");

        // Zero h-count: straight to DONE, no reads; the accepted start clears err.
        s = cyc;
        num_h_i = 8'd0; num_p_i = 8'd5; start_i = 1'b1;
        done_q.push_back(s + 1);
        tick();
        start_i = 1'b0;
        wait_done(10);
        tick();
        queues_empty("zero_job");
        check("zero_job_err", err_o, 0);

        // Pop with all credits home: error, and the credit count must not grow.
        out_pop_i = 1'b1;
        tick();
        out_pop_i = 1'b0;
        tick();
        check("pop_full_err", err_o, 1);

        // 1x8 with no pops: exactly OUT_DEPTH issues, then a stall.
        s = cyc;
        num_h_i = 8'd1; num_p_i = 8'd8; start_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_iss(s + 1 + i, 0, i);
            push_mul(s + 2 + i, 1'b0);
        end
        tick();
        start_i = 1'b0;
        repeat (11) tick();
        queues_empty("stall");
        check("stall_busy", busy_o, 1);
        check("stall_err_cleared", err_o, 0);

        s = cyc;
        out_pop_i = 1'b1;
        push_iss(s + 1, 0, 4);
        push_mul(s + 2, 1'b0);
        tick();
        out_pop_i = 1'b0;
        repeat (9) tick();
        queues_empty("one_pop");

        s = cyc;
        out_pop_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_iss(s + 1 + i, 0, 5 + i);
            push_mul(s + 2 + i, i == 2);
        end
        done_q.push_back(s + 11);
        wait_done(30);
        out_pop_i = 1'b0;
        tick();
        tick();
        queues_empty("stall_finish");

        // start_i during RUN and during DRAIN must not disturb the 1x3 job.
        s = cyc;
        num_h_i = 8'd1; num_p_i = 8'd3; start_i = 1'b1; out_pop_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_iss(s + 1 + i, 0, i);
            push_mul(s + 2 + i, i == 2);
        end
        done_q.push_back(s + 11);
        tick();
        start_i = 1'b0;
        tick();
        num_h_i = 8'd5; num_p_i = 8'd5; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done(20);
        out_pop_i = 1'b0;
        tick();
        tick();
        queues_empty("restart_ignored");
        check("restart_idle_busy", busy_o, 0);

        // Reset after three issues aborts at once; a fresh job starts from index 0.
        s = cyc;
        num_h_i = 8'd2; num_p_i = 8'd3; start_i = 1'b1;
        for (int i = 0; i < 3; i++) push_iss(s + 1 + i, 0, i);
        push_mul(s + 2, 1'b0);
        push_mul(s + 3, 1'b0);
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        rstn = 1'b0;
        #1 check_all_zero("abort");
        tick();
        tick();
        rstn = 1'b1;
        tick();
        queues_empty("abort");

        run_2x3("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
